// File: rtl/buffer_stream_ctrl.sv
// Fill/drain sequencer for a banked synchronous-read row buffer: streams words
// into D banks row by row, then replays whole rows to a valid/ready consumer.
module buffer_stream_ctrl #(
  parameter int depth = 2,
  parameter int A     = 7,
  parameter int D     = 1 << depth,
  parameter int W     = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  input  logic [A:0]       numRows,
  input  logic [W-1:0]     inData,
  input  logic             inValid,
  output logic             inReady,
  output logic [A-1:0]     address,
  output logic             ioSelect,
  output logic             ioWrite,
  output logic [depth-1:0] ioBankSelect,
  output logic [W-1:0]     ioInput,
  output logic             rowValid,
  input  logic             rowReady,
  output logic             rowLast,
  output logic             busy,
  output logic             done
);

  // Handshakes: a fill word transfers on a cycle with inValid && inReady; a
  // row transfers on a cycle with rowValid && rowReady. rowValid never drops
  // and the presented row never changes until that row has transferred.

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [A:0]       MAX_ROWS  = {1'b1, {A{1'b0}}};
  localparam logic [depth-1:0] BANK_LAST = depth'(D - 1);

  logic [1:0]       state_q, state_d;
  logic [A:0]       rows_q, rows_d;
  logic [A:0]       row_q, row_d;
  logic [depth-1:0] bank_q, bank_d;
  logic [A-1:0]     pres_q, pres_d;
  logic             valid_q, valid_d;

  logic fill_hs, bank_wrap, last_fill_row, rows_left, issue, accept, last_row;
  logic [A:0] rows_sat;

  always_comb begin
    rows_sat      = (numRows > MAX_ROWS) ? MAX_ROWS : numRows;
    fill_hs       = (state_q == FILL) && inValid;
    bank_wrap     = (bank_q == BANK_LAST);
    last_fill_row = (row_q == rows_q - 1'b1);
    rows_left     = (row_q < rows_q);
    issue         = (state_q == DRAIN) && rows_left && (!valid_q || rowReady);
    accept        = valid_q && rowReady;
    last_row      = valid_q && ({1'b0, pres_q} == rows_q - 1'b1);
  end

  always_comb begin
    state_d = state_q;
    rows_d  = rows_q;
    row_d   = row_q;
    bank_d  = bank_q;
    pres_d  = pres_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          rows_d  = rows_sat;
          row_d   = '0;
          bank_d  = '0;
          state_d = (numRows == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        if (fill_hs) begin
          bank_d = bank_wrap ? '0 : bank_q + 1'b1;
          if (bank_wrap) begin
            if (last_fill_row) begin
              state_d = DRAIN;
              row_d   = '0;
            end else begin
              row_d = row_q + 1'b1;
            end
          end
        end
      end
      DRAIN: begin
        // Issuing reloads the SRAM read; the row lands on op next cycle.
        if (issue) begin
          row_d   = row_q + 1'b1;
          pres_d  = row_q[A-1:0];
          valid_d = 1'b1;
        end else if (accept) begin
          valid_d = 1'b0;
        end
        if (accept && last_row) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        row_d   = '0;
        bank_d  = '0;
        pres_d  = '0;
        valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      rows_q  <= '0;
      row_q   <= '0;
      bank_q  <= '0;
      pres_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      row_q   <= row_d;
      bank_q  <= bank_d;
      pres_q  <= pres_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    inReady      = (state_q == FILL);
    ioSelect     = (state_q == FILL);
    ioWrite      = fill_hs;
    ioInput      = (state_q == FILL) ? inData : '0;
    ioBankSelect = (state_q == FILL) ? bank_q : '0;
    address      = '0;
    if (state_q == FILL) begin
      address = row_q[A-1:0];
    end else if (state_q == DRAIN) begin
      // Re-presenting the held row keeps op stable while the consumer stalls.
      address = issue ? row_q[A-1:0] : pres_q;
    end
    rowValid = valid_q;
    rowLast  = last_row;
    busy     = (state_q == FILL) || (state_q == DRAIN);
    done     = (state_q == DONE);
  end

endmodule

// File: doc/buffer_stream_ctrl.md
BUFFER_STREAM_CTRL -- requirements
Module: buffer_stream_ctrl

Interface
REQ-001 Parameters (name, default, meaning) SHALL be exactly these four:
- depth, 2, log2 of bank count.
- A, 7, SRAM address width.
- D, 1<<depth, bank count and convolutional unit size.
- W, 16, data word width.

REQ-002 Ports (name, direction, width, meaning) SHALL be exactly these, clock and reset first:
- CLK, in, 1, the single clock, rising edge.
- nRST, in, 1, asynchronous active-low reset.
- start, in, 1, begin one fill/drain job.
- numRows, in, A+1, rows to process, sampled on accepted start.
- inData, in, W, fill stream word.
- inValid, in, 1, fill word valid.
- inReady, out, 1, fill word accepted.
- address, out, A, to buffer address.
- ioSelect, out, 1, to buffer io path enable.
- ioWrite, out, 1, to buffer write strobe.
- ioBankSelect, out, depth, to buffer bank select.
- ioInput, out, W, to buffer io write data.
- rowValid, out, 1, buffer op holds a valid row for the consumer.
- rowReady, in, 1, consumer accepts the row.
- rowLast, out, 1, current row is the final row.
- busy, out, 1, job in progress.
- done, out, 1, one-cycle job-complete pulse.

REQ-003 The buffer's row output (op, D*W) SHALL be consumed directly by the downstream unit; this block only qualifies it with rowValid/rowLast.

REQ-004 The buffer SRAM SHALL be treated as synchronous read: op reflects the address presented at the previous rising edge.

Function
REQ-005 States SHALL be IDLE, FILL, DRAIN, DONE.
REQ-006 IDLE: start=1 latches numRows; the next state is FILL if numRows!=0, else DONE.
REQ-007 start SHALL be ignored in every state other than IDLE.
REQ-008 FILL SHALL drive inReady=1, ioSelect=1, ioWrite=inValid (combinational), ioInput=inData (combinational), ioBankSelect=bank counter, and address=row counter.
REQ-009 Each FILL handshake (inValid&&inReady) SHALL increment the bank counter, wrapping D-1 to 0.
REQ-010 The row counter SHALL increment on bank wrap, so word k is written to bank k mod D at row k div D.
REQ-011 The handshake that writes bank D-1 of row numRows-1 SHALL move the state to DRAIN and clear the row counter to 0.
REQ-012 inReady, ioSelect and ioWrite SHALL be 0 in all states except FILL.
REQ-013 DRAIN SHALL use an issue condition: a row is issued when rows remain and (rowValid==0 || rowReady==1).
REQ-014 An issue SHALL present the row counter on address, then increment the row counter.
REQ-015 rowValid SHALL be set one cycle after an issue.
REQ-016 rowValid SHALL clear when rowReady && rowValid occurs and no new issue occurs in the same cycle.
REQ-017 While rowValid && !rowReady, address SHALL be held so op stays stable.
REQ-018 Throughput SHALL be 1 row per cycle when rowReady is held at 1.
REQ-019 rowLast SHALL equal rowValid && (presented row == numRows-1).
REQ-020 Acceptance of the last row (rowValid&&rowReady&&rowLast) SHALL move the state to DONE.
REQ-021 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-022 busy SHALL be 1 in FILL and DRAIN, and 0 in IDLE and DONE.
REQ-023 numRows > 2^A SHALL be saturated to 2^A when latched.
REQ-024 The counters SHALL be sized so that row 2^A-1 is the last addressed row without wrap errors.
REQ-025 If FILL never reaches its count because inValid stalls, the block SHALL wait indefinitely with no timeout.

Reset
REQ-026 nRST=0 SHALL act asynchronously, including mid-FILL and mid-DRAIN, and force:
- state IDLE and all counters 0;
- inReady, ioSelect, ioWrite, rowValid, rowLast, busy and done all 0;
- address 0 and ioBankSelect 0.
REQ-027 After nRST is released, a new start SHALL be needed; no partial job SHALL resume.

Verification
REQ-028 D=4, numRows=2, inData 1..8 with inValid held at 1:
- required writes are bank/row (0,0)=1, (1,0)=2, (2,0)=3, (3,0)=4, (0,1)=5 ... (3,1)=8;
- then rowValid for row 0 (op={4,3,2,1}) and row 1 (op={8,7,6,5}, rowLast=1) on consecutive cycles;
- then done=1 for one cycle.
REQ-029 Same job, rowReady=0 for 3 cycles while row 0 is valid -> address stays 0, op stays stable, rowValid stays 1, and row 1 follows only after rowReady rises.
REQ-030 inValid toggled every other cycle during FILL -> exactly 8 writes with no skipped or duplicated bank/row pairs, and ioWrite=0 on idle cycles.
REQ-031 numRows=0 with start -> DONE the next cycle, done=1 for one cycle, and no ioWrite or rowValid ever asserted.
REQ-032 nRST pulsed low after 3 FILL writes -> all outputs 0 immediately; after release, a new start with numRows=1 writes from bank 0 row 0.
REQ-033 start asserted during DRAIN -> ignored, and the current job completes unchanged.
